// File: rtl/ifetch_pkg.sv
// ifetch shared types: FSM state, widths and the prefetch FIFO entry.
// Imported by ifetch and ifetch_fifo.
package ifetch_pkg;

   localparam int ADDR_W = 16;
   localparam int BYTE_W = 8;
   localparam int INS_W  = 16;

   typedef enum logic {
      S_HI,
      S_LO
   } state_t;

   typedef struct packed {
      logic [INS_W-1:0]  ins;
      logic [ADDR_W-1:0] pc;
   } entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO: push/pop, synchronous flush, registered head entry.
// Ports: clk, reset, flush, push, wdata, pop, head, valid, full.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   flush,
   input  logic   push,
   input  entry_t wdata,
   input  logic   pop,
   output entry_t head,
   output logic   valid,
   output logic   full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            do_pop;

   assign valid  = (count != '0);
   assign full   = (count == CW'(DEPTH));
   assign do_pop = pop && valid;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (flush) begin
         // flush wins over any same-cycle push or pop
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !do_pop)
            count <= count + CW'(1);
         else if (!push && do_pop)
            count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: reads two bytes per instruction, big-endian,
// into a prefetch FIFO drained by decode; redirect flushes and restarts.
// Ports: clk, reset, mem_raddr/mem_rdata, redirect/redirect_pc,
// ins_valid, ins, ins_pc, ins_ready.
module ifetch
   import ifetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [15:0]     RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] mem_raddr,
   input  logic [7:0]  mem_rdata,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        ins_valid,
   output logic [15:0] ins,
   output logic [15:0] ins_pc,
   input  logic        ins_ready
);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pc_nx;
   logic [BYTE_W-1:0] hi_byte;
   logic [BYTE_W-1:0] hi_nx;
   logic              push;
   logic              full;
   entry_t            wdata;
   entry_t            head;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_HI;
         fetch_pc <= RESET_PC;
         hi_byte  <= '0;
      end else begin
         state    <= state_nx;
         fetch_pc <= pc_nx;
         hi_byte  <= hi_nx;
      end
   end

   // address depends on state and fetch_pc only, never on mem_rdata
   always_comb begin
      state_nx  = state;
      pc_nx     = fetch_pc;
      hi_nx     = hi_byte;
      push      = 1'b0;
      mem_raddr = fetch_pc;
      unique case (state)
         S_HI: begin
            if (!full) begin
               hi_nx    = mem_rdata;
               state_nx = S_LO;
            end
         end
         S_LO: begin
            mem_raddr = fetch_pc + 16'd1;
            push      = 1'b1;
            pc_nx     = fetch_pc + 16'd2;
            state_nx  = S_HI;
         end
         default: state_nx = S_HI;
      endcase
      if (redirect) begin
         state_nx = S_HI;
         pc_nx    = redirect_pc;
      end
   end

   assign wdata.ins = {hi_byte, mem_rdata};
   assign wdata.pc  = fetch_pc;

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect),
      .push  (push),
      .wdata (wdata),
      .pop   (ins_ready),
      .head  (head),
      .valid (ins_valid),
      .full  (full)
   );

   assign ins    = head.ins;
   assign ins_pc = head.pc;

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the initiator on the byte-wide asynchronous-read port of the instruction memory. It walks a fetch PC and reads two consecutive bytes per instruction. It assembles each pair into a 16-bit big-endian instruction word and buffers the result in a small prefetch FIFO, which the decode stage drains with a valid/ready handshake. A redirect from execute flushes the buffer and restarts fetch at a new PC.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, ≥2
- RESET_PC, 16'h0000: fetch PC after reset

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- mem_raddr  out  16  byte address to instruction memory read port
- mem_rdata  in  8  byte returned combinationally for mem_raddr in the same cycle
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  16  new fetch PC; odd values are legal
- ins_valid  out  1  FIFO head holds an instruction
- ins  out  16  head instruction, {byte@pc, byte@pc+1}
- ins_pc  out  16  address of the head instruction's high byte
- ins_ready  in  1  consumer accepts head this cycle

## Operation
- State: fetch_pc (16 bits), hi_byte (8 bits), FSM {HI, LO}, FIFO with count 0..DEPTH.
- **HI:**
  - mem_raddr = fetch_pc.
  - If count < DEPTH: hi_byte <= mem_rdata, go to LO.
  - Otherwise stall in HI; the read is harmless.
- **LO:**
  - mem_raddr = fetch_pc + 1 (mod 2^16).
  - Push {hi_byte, mem_rdata} tagged fetch_pc.
  - fetch_pc <= fetch_pc + 2 (mod 2^16), go to HI.
  - Space is guaranteed because HI only advances when count < DEPTH and only LO pushes.
- **Pop:** occurs when ins_valid && ins_ready. A push and a pop in the same cycle leave count unchanged.
- **Redirect** has priority over all else:
  - fetch_pc <= redirect_pc, FSM <= HI, count <= 0, pointers <= 0.
  - Any partial hi_byte is discarded.
  - A pop coincident with redirect counts as consumed; a push coincident with redirect is dropped.
- **Wrap-around:**
  - PC FFFF reads its low byte at 0000.
  - The next fetch_pc is 0001.
- **Reset** (also mid-instruction):
  - fetch_pc = RESET_PC, FSM = HI, count = 0.
  - ins_valid = 0, mem_raddr = RESET_PC.
  - ins and ins_pc are 0.
- ins and ins_pc are don't-care while ins_valid = 0.

## Timing
- ins_valid, ins, ins_pc come from registers: FIFO head and count.
- mem_raddr is combinational from fetch_pc and FSM only, with no path from mem_rdata.
- First instruction after reset release or redirect:
  - cycle 0 reads the high byte, cycle 1 reads the low byte and pushes;
  - ins_valid = 1 in cycle 2.
- Throughput: one instruction per 2 cycles while not full.
- Full: with count = DEPTH and no pop, the FSM holds HI. If a pop occurs in cycle n, HI advances in cycle n+1 and the push lands in n+2.
- Redirect asserted in cycle n: ins_valid = 0 in n+1, and the new instruction is valid in n+3.
- The consumer may hold ins_ready high continuously. ins_ready while ins_valid = 0 has no effect.

## Structure
- Package ifetch_pkg holds:
  - FSM state enum {S_HI, S_LO};
  - ADDR_W = 16, BYTE_W = 8, INS_W = 16;
  - the FIFO entry struct {ins[15:0], pc[15:0]}.
- One sub-module: ifetch_fifo.
  - Parameterised DEPTH, synchronous flush, push/pop, count, registered head.
  - The top level holds the FSM, fetch_pc, hi_byte and the address mux.
- Memory model for the bench: the existing byte memory, preloaded from hex.

## Test plan
- **Reset and steady fetch:** memory 0000..0005 = 12 34 56 78 9A BC, ins_ready = 1.
  - Expected: (1234, pc 0000) valid at cycle 2, (5678, 0002) at 4, (9ABC, 0004) at 6.
- **Backpressure:** ins_ready = 0, DEPTH = 4.
  - Expected: count reaches 4 after 8 cycles; mem_raddr then holds 0008 with no further pushes.
  - Raise ins_ready for one cycle: exactly one entry is popped and one is refilled two cycles later; order is preserved.
- **Redirect mid-instruction:** assert redirect to 0100 while in LO with 2 entries queued.
  - Expected: ins_valid = 0 next cycle, no stale entry ever appears, and the first valid is pc 0100 three cycles after the redirect.
- **Redirect coincident with a pop and a push:** head is accepted, the pushed entry is dropped, and the FIFO is empty next cycle.
- **Wrap and odd PC:** redirect to FFFF with memory FFFF = AB, 0000 = CD.
  - Expected: ins = ABCD, ins_pc = FFFF; next ins_pc = 0001.
- **Reset mid-operation:** assert reset with the FIFO full and the FSM in LO.
  - Expected: next cycle ins_valid = 0 and mem_raddr = RESET_PC; fetch restarts cleanly.
